apb_master: RTL and testbench

Bridges a simple valid/ready command port onto the APB bus that hosts the 8-bit timer and its peers. One command becomes one APB3 transfer (SETUP then ACCESS with wait states), and its result comes back on a valid/ready response port. This block is the initiator that drives PSEL/PENABLE toward the timer's APB slave, for use by a local controller or test sequencer. Only one transfer is outstanding at a time, and a bounded PREADY timeout protects the bus from a hung slave.

---
 rtl/apb_master_if.sv | 38 +++
 rtl/apb_master.sv | 131 +++++++++++++
 tb/tb_apb_master.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response and APB signal bundle for apb_master
interface apb_master_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              PSEL;
   logic              PENABLE;
   logic              PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      input  PRDATA, PREADY, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
      output PRDATA, PREADY, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - valid/ready command port to APB3 initiator with PREADY timeout
module apb_master #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   apb_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   localparam bit         TO_EN   = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [7:0]        wait_q, wait_d;
   logic              cmd_ready_q, cmd_ready_d;
   logic              psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [ADDR_W-1:0] paddr_q, paddr_d;
   logic [DATA_W-1:0] pwdata_q, pwdata_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
   logic              rsp_err_q, rsp_err_d;
   logic              rsp_timeout_q, rsp_timeout_d;

   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
      unique case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               pwrite_d = bus.cmd_write;
               paddr_d  = bus.cmd_addr;
               pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
               psel_d   = 1'b1;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            penable_d = 1'b1;
            wait_d    = '0;
            state_d   = ACCESS;
         end
         ACCESS: begin
            // A completing PREADY takes priority over the timeout limit on the same edge.
            if (bus.PREADY) begin
               rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
               rsp_err_d     = bus.PSLVERR;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = RESP;
            end else if (TO_EN && wait_q == TO_LAST) begin
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = 1'b1;
               psel_d        = 1'b0;
               penable_d     = 1'b0;
               state_d       = RESP;
            end else if (TO_EN) begin
               wait_d = wait_q + 8'd1;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d   = 1'b0;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b0;
               rsp_timeout_d = 1'b0;
               state_d       = IDLE;
            end
         end
      endcase
      cmd_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q       <= IDLE;
         wait_q        <= '0;
         cmd_ready_q   <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         cmd_ready_q   <= cmd_ready_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.PSEL        = psel_q;
   assign bus.PENABLE     = penable_q;
   assign bus.PWRITE      = pwrite_q;
   assign bus.PADDR       = paddr_q;
   assign bus.PWDATA      = pwdata_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master
module tb_apb_master;
   logic PCLK = 1'b0;
   logic PRESET;

   apb_master_if #(.ADDR_W(8), .DATA_W(8)) b ();

   apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
      .PCLK   (PCLK),
      .PRESET (PRESET),
      .bus    (b)
   );

   always #5 PCLK = ~PCLK;

   typedef struct packed {
      logic [7:0] rdata;
      logic       err;
      logic       to;
   } rsp_t;

   rsp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   // Response monitor: a handshake seen at the negedge completes on the next posedge.
   always @(negedge PCLK) begin
      if (!PRESET && b.rsp_valid && b.rsp_ready) begin
         if (exp_q.size() == 0) begin
            chk("rsp_unexpected", 32'd1, 32'd0);
         end else begin
            rsp_t e;
            e = exp_q.pop_front();
            chk("rsp_rdata", b.rsp_rdata, e.rdata);
            chk("rsp_err", b.rsp_err, e.err);
            chk("rsp_timeout", b.rsp_timeout, e.to);
         end
      end
   end

   task automatic push(input logic [7:0] rd, input logic err, input logic to);
      rsp_t e;
      e.rdata = rd;
      e.err   = err;
      e.to    = to;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] rd, input logic err, output int g);
      logic r;
      b.cmd_write = wr;
      b.cmd_addr  = a;
      b.cmd_wdata = wd;
      b.cmd_valid = 1'b1;
      b.PREADY    = 1'b0;
      b.PRDATA    = rd;
      b.PSLVERR   = err;
      g = 0;
      do begin
         r = b.cmd_ready;
         tick();
         g++;
      end while (!r && g < 50);
      if (!r) chk("accept_bound", 32'd0, 32'd1);
      b.cmd_valid = 1'b0;
   endtask

   // Called in the SETUP cycle; returns in the first cycle after ACCESS ends.
   task automatic finish_access(input int waits, input logic wr, input logic [7:0] a,
                                input logic [7:0] wd, output int acc);
      logic stable;
      stable = 1'b1;
      acc = 0;
      chk("setup_psel", b.PSEL, 1);
      chk("setup_penable", b.PENABLE, 0);
      tick();
      while (b.PENABLE && acc < 300) begin
         acc++;
         stable &= b.PSEL && b.PADDR == a && b.PWRITE == wr && b.PWDATA == (wr ? wd : 8'h00);
         b.PREADY = (waits >= 0 && acc == waits + 1);
         tick();
      end
      b.PREADY = 1'b0;
      chk("access_stable", stable, 1);
      chk("resp_valid", b.rsp_valid, 1);
      chk("resp_psel", b.PSEL, 0);
   endtask

   task automatic run(input logic wr, input logic [7:0] a, input logic [7:0] wd, input int waits,
                      input logic [7:0] rd, input logic err, output int acc);
      int g;
      issue(wr, a, wd, rd, err, g);
      finish_access(waits, wr, a, wd, acc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int g;
      PRESET      = 1'b1;
      b.cmd_valid = 1'b0;
      b.cmd_write = 1'b0;
      b.cmd_addr  = '0;
      b.cmd_wdata = '0;
      b.rsp_ready = 1'b1;
      b.PRDATA    = '0;
      b.PREADY    = 1'b0;
      b.PSLVERR   = 1'b0;
      tick();
      tick();
      chk("rst_cmd_ready", b.cmd_ready, 0);
      chk("rst_psel", b.PSEL, 0);
      chk("rst_penable", b.PENABLE, 0);
      chk("rst_rsp_valid", b.rsp_valid, 0);
      chk("rst_bus", {b.PWRITE, b.PADDR, b.PWDATA}, 0);
      PRESET = 1'b0;
      tick();
      chk("post_rst_cmd_ready", b.cmd_ready, 1);

      // Write, zero wait states
      push(8'h00, 1'b0, 1'b0);
      issue(1'b1, 8'h00, 8'h5A, 8'hEE, 1'b0, g);
      chk("wr_pwrite", b.PWRITE, 1);
      chk("wr_pwdata", b.PWDATA, 8'h5A);
      finish_access(0, 1'b1, 8'h00, 8'h5A, acc);
      chk("wr_access_cycles", acc, 1);
      tick();
      chk("wr_back_idle", b.cmd_ready, 1);

      // Read, 2 wait states
      push(8'hC3, 1'b0, 1'b0);
      run(1'b0, 8'h03, 8'hFF, 2, 8'hC3, 1'b0, acc);
      chk("rd_access_cycles", acc, 3);
      tick();

      // Slave error
      push(8'h77, 1'b1, 1'b0);
      run(1'b0, 8'h05, 8'h00, 0, 8'h77, 1'b1, acc);
      chk("err_access_cycles", acc, 1);
      tick();

      // Timeout with PREADY stuck low
      push(8'h00, 1'b1, 1'b1);
      run(1'b0, 8'h06, 8'h00, -1, 8'h99, 1'b0, acc);
      chk("to_access_cycles", acc, 16);
      tick();

      // PREADY on the 16th ACCESS cycle completes normally
      push(8'h4B, 1'b0, 1'b0);
      run(1'b0, 8'h07, 8'h00, 15, 8'h4B, 1'b0, acc);
      chk("to_edge_access_cycles", acc, 16);
      tick();

      push(8'h00, 1'b0, 1'b0);
      run(1'b1, 8'h08, 8'h12, 1, 8'h00, 1'b0, acc);
      chk("post_to_access_cycles", acc, 2);
      tick();

      // Response backpressure with a second command waiting
      b.rsp_ready = 1'b0;
      push(8'h3C, 1'b0, 1'b0);
      run(1'b0, 8'h10, 8'h00, 0, 8'h3C, 1'b0, acc);
      b.cmd_write = 1'b1;
      b.cmd_addr  = 8'h21;
      b.cmd_wdata = 8'h99;
      b.cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {b.rsp_valid, b.cmd_ready, b.rsp_rdata, b.rsp_err}, {1'b1, 1'b0, 8'h3C, 1'b0});
         tick();
      end
      b.rsp_ready = 1'b1;
      push(8'h00, 1'b0, 1'b0);
      issue(1'b1, 8'h21, 8'h99, 8'h00, 1'b0, g);
      chk("bp_accept_latency", g, 2);
      finish_access(0, 1'b1, 8'h21, 8'h99, acc);
      tick();

      // Reset during a wait state
      issue(1'b1, 8'h44, 8'hA5, 8'h00, 1'b0, g);
      tick();
      tick();
      chk("pre_rst_penable", b.PENABLE, 1);
      PRESET = 1'b1;
      tick();
      PRESET = 1'b0;
      chk("midrst_ctrl", {b.PSEL, b.PENABLE, b.rsp_valid, b.cmd_ready}, 0);
      chk("midrst_bus", {b.PWRITE, b.PADDR, b.PWDATA}, 0);
      chk("midrst_rsp", {b.rsp_rdata, b.rsp_err, b.rsp_timeout}, 0);
      tick();
      chk("midrst_cmd_ready", b.cmd_ready, 1);
      for (int i = 0; i < 4; i++) tick();
      chk("midrst_no_rsp", b.rsp_valid, 0);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
